// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: control state encoding, register index width, bubble word.
// Pure declarations, no logic, no latency.
// Imported by the hazard controller and by the inter-stage latches.
package hazard_ctrl_pkg;

    // Register index width of the integer register file
    localparam int REG_W = 5;

    // All-zero NOP word that a latch loads when told to insert a bubble
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: latch enables/bubbles for load-use, branch flush and memory freeze.
// Zero-cycle decode of enables and bubbles; state and counters update on the stg_clk rising edge.
// A pending data-memory access freezes every latch and the PC until mem_ready.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             stg_clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rd_memory,
    input  logic             ex_save_to_reg,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_ena,
    output logic             ifid_ena,
    output logic             idex_ena,
    output logic             exmem_ena,
    output logic             memwb_ena,
    output logic             ifid_x,
    output logic             idex_x,
    output logic             exmem_x,
    output logic             mem_timeout,
    output logic [15:0]      stall_count
);

    // Extra IF/ID bubbles after the first flush cycle
    localparam logic [15:0] FLUSH_RES = 16'(FLUSH_CYCLES - 1);
    localparam logic [31:0] TMO_LIMIT = 32'(MEM_TIMEOUT);

    state_t      state;
    state_t      saved_state;
    state_t      eff_state;
    logic [15:0] flush_cnt;
    logic [31:0] wait_cnt;
    logic        frozen;
    logic        do_branch;
    logic        do_load_use;

    // A load in EX whose destination is read by the instruction in ID
    function automatic logic load_use_hit(
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic [REG_W-1:0] rd,
        input logic             rs1_used,
        input logic             rs2_used,
        input logic             is_load,
        input logic             writes_rd
    );
        return is_load && writes_rd && (rd != '0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

    // Hazard decode; while waiting on memory the saved state decides what happens on release
    always_comb begin
        eff_state   = (state == ST_MEM_WAIT) ? saved_state : state;
        frozen      = mem_req && !mem_ready;
        do_branch   = !frozen && (eff_state == ST_RUN) && branch_taken;
        do_load_use = !frozen && (eff_state == ST_RUN) && !branch_taken &&
                      load_use_hit(id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used,
                                   ex_rd_memory, ex_save_to_reg);
    end

    // Latch control outputs, priority freeze > branch flush > load-use; all zero in reset
    always_comb begin
        pc_ena    = 1'b0;
        ifid_ena  = 1'b0;
        idex_ena  = 1'b0;
        exmem_ena = 1'b0;
        memwb_ena = 1'b0;
        ifid_x    = 1'b0;
        idex_x    = 1'b0;
        exmem_x   = 1'b0;
        if (!reset && !frozen) begin
            pc_ena    = 1'b1;
            ifid_ena  = 1'b1;
            idex_ena  = 1'b1;
            exmem_ena = 1'b1;
            memwb_ena = 1'b1;
            if (do_branch) begin
                ifid_x = 1'b1;
                idex_x = 1'b1;
            end else if (eff_state == ST_FLUSH) begin
                ifid_x = 1'b1;
            end else if (do_load_use) begin
                pc_ena   = 1'b0;
                ifid_ena = 1'b0;
                idex_x   = 1'b1;
            end
        end
    end

    // State, flush residue, wait/timeout tracking and stall statistics
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!pc_ena && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (frozen) begin
                // Remember where to resume; flush_cnt is left untouched so the residue survives
                if (state != ST_MEM_WAIT) begin
                    saved_state <= state;
                end
                state <= ST_MEM_WAIT;
                if (wait_cnt != TMO_LIMIT) begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
                // Flag is registered: it is raised by the edge that ends the MEM_TIMEOUT-th wait cycle
                if ((wait_cnt + 32'd1) >= TMO_LIMIT) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
                case (eff_state)
                    ST_RUN: begin
                        if (branch_taken && (FLUSH_CYCLES > 1)) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_RES;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt <= 16'd1) begin
                            state     <= ST_RUN;
                            flush_cnt <= '0;
                        end else begin
                            state     <= ST_FLUSH;
                            flush_cnt <= flush_cnt - 16'd1;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl with FLUSH_CYCLES=2 and MEM_TIMEOUT=2.
// Expected outputs are queued when a cycle is driven and checked at the falling edge.
// Fixed-length stimulus; no unbounded waits.
module tb_hazard_ctrl;

    logic       stg_clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_rd_memory, ex_save_to_reg;
    logic       branch_taken, mem_req, mem_ready;
    logic       pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
    logic       ifid_x, idex_x, exmem_x, mem_timeout;
    logic [15:0] stall_count;

    hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(2)) dut (
        .stg_clk(stg_clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_save_to_reg(ex_save_to_reg),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_ena(pc_ena), .ifid_ena(ifid_ena), .idex_ena(idex_ena),
        .exmem_ena(exmem_ena), .memwb_ena(memwb_ena),
        .ifid_x(ifid_x), .idex_x(idex_x), .exmem_x(exmem_x),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    initial stg_clk = 1'b0;
    always #5 stg_clk = ~stg_clk;

    // {pc, ifid, idex, exmem, memwb, ifid_x, idex_x, exmem_x}
    localparam logic [7:0] C_ALL = 8'b11111_000;
    localparam logic [7:0] C_LU  = 8'b00111_010;
    localparam logic [7:0] C_BR  = 8'b11111_110;
    localparam logic [7:0] C_FL  = 8'b11111_100;
    localparam logic [7:0] C_FRZ = 8'b00000_000;
    localparam logic [7:0] C_OFF = 8'b00000_000;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       sv;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } in_t;

    typedef struct packed {
        logic [7:0]  ctl;
        logic        tmo_chk;
        logic        tmo;
        logic [15:0] stall;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] exp_stall;
    int          total;
    int          bad;
    logic [7:0]  ctl_obs;

    assign ctl_obs = {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena, ifid_x, idex_x, exmem_x};

    function automatic in_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd, input logic ld,
                               input logic sv, input logic br, input logic mreq,
                               input logic mrdy);
        in_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
        v.ld = ld; v.sv = sv; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        return v;
    endfunction

    task automatic apply(input in_t v);
        id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
        ex_rd = v.rd; ex_rd_memory = v.ld; ex_save_to_reg = v.sv;
        branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    // Drive one cycle and queue what the controller must show for it
    task automatic drive(input in_t v, input logic [7:0] ctl, input logic tmo_chk, input logic tmo);
        exp_t x;
        apply(v);
        x.ctl = ctl; x.tmo_chk = tmo_chk; x.tmo = tmo; x.stall = exp_stall;
        sb.push_back(x);
        if (!ctl[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e.ctl = C_OFF; e.tmo_chk = 1'b1; e.tmo = 1'b0; e.stall = 16'd0;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        total++;
        if (ctl_obs !== e.ctl || stall_count !== e.stall || mem_timeout !== e.tmo) begin
            bad++;
            $display("FAIL reset: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                     ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
        end
        @(posedge stg_clk); @(posedge stg_clk); #1;
        reset = 1'b0;
        exp_stall = 16'd0;
    endtask

    task automatic test_load_use;
        in_t        s[5];
        logic [7:0] c[5];
        s[0] = mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0); c[0] = C_LU;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[1] = C_ALL;
        s[2] = mk(3, 1, 7, 1, 7, 1, 1, 0, 0, 0); c[2] = C_LU;
        s[3] = mk(7, 0, 2, 1, 7, 1, 1, 0, 0, 0); c[3] = C_ALL;
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[4] = C_ALL;
        for (int i = 0; i < 5; i++) begin
            drive(s[i], c[i], 1'b1, 1'b0);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL load_use[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    task automatic test_no_stall;
        in_t s[3];
        s[0] = mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        s[1] = mk(5, 1, 0, 0, 5, 0, 1, 0, 0, 0);
        s[2] = mk(5, 1, 5, 1, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(s[i], C_ALL, 1'b1, 1'b0);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL no_stall[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    // lu=1 adds a simultaneous load-use pattern on the branch cycle
    task automatic test_branch(input logic lu, input string nm);
        in_t        s[3];
        logic [7:0] c[3];
        s[0] = lu ? mk(6, 1, 0, 0, 6, 1, 1, 1, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        c[0] = C_BR;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[1] = C_FL;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[2] = C_ALL;
        for (int i = 0; i < 3; i++) begin
            drive(s[i], c[i], 1'b1, 1'b0);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL %s[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         nm, i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    task automatic test_mem_freeze;
        in_t        s[6];
        logic [7:0] c[6];
        logic       k[6];
        logic       t[6];
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); c[0] = C_FRZ; k[0] = 1; t[0] = 0;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); c[1] = C_FRZ; k[1] = 0; t[1] = 0;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); c[2] = C_FRZ; k[2] = 1; t[2] = 1;
        s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); c[3] = C_ALL; k[3] = 1; t[3] = 1;
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); c[4] = C_ALL; k[4] = 1; t[4] = 1;
        s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[5] = C_ALL; k[5] = 1; t[5] = 1;
        for (int i = 0; i < 6; i++) begin
            drive(s[i], c[i], k[i], t[i]);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL mem_freeze[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    // Freeze lands on the second flush cycle; branch_taken during the freeze is ignored
    task automatic test_freeze_in_flush;
        in_t        s[5];
        logic [7:0] c[5];
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); c[0] = C_BR;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); c[1] = C_FRZ;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); c[2] = C_FRZ;
        s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); c[3] = C_FL;
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[4] = C_ALL;
        for (int i = 0; i < 5; i++) begin
            drive(s[i], c[i], 1'b1, 1'b1);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL freeze_in_flush[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    // A branch held in EX through a freeze takes effect on the release cycle
    task automatic test_branch_on_release;
        in_t        s[4];
        logic [7:0] c[4];
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); c[0] = C_FRZ;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); c[1] = C_BR;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[2] = C_FL;
        s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[3] = C_ALL;
        for (int i = 0; i < 4; i++) begin
            drive(s[i], c[i], 1'b1, 1'b1);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL branch_release[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait;
        in_t        s[3];
        logic [7:0] c[3];
        for (int i = 0; i < 2; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_FRZ, 1'b1, 1'b1);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL pre_reset_wait[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
        // Asynchronous reset in the middle of a wait cycle
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        #1 reset = 1'b1;
        e.ctl = C_OFF; e.tmo_chk = 1'b1; e.tmo = 1'b0; e.stall = 16'd0;
        sb.push_back(e);
        exp_stall = 16'd0;
        #1;
        e = sb.pop_front();
        total++;
        if (ctl_obs !== e.ctl || stall_count !== e.stall || mem_timeout !== e.tmo) begin
            bad++;
            $display("FAIL reset_mid_wait: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                     ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
        end
        @(posedge stg_clk); #1;
        reset = 1'b0;
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[0] = C_ALL;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); c[1] = C_BR;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); c[2] = C_FL;
        for (int i = 0; i < 3; i++) begin
            drive(s[i], c[i], 1'b1, 1'b0);
            @(negedge stg_clk);
            e = sb.pop_front();
            total++;
            if (ctl_obs !== e.ctl || stall_count !== e.stall || (e.tmo_chk && mem_timeout !== e.tmo)) begin
                bad++;
                $display("FAIL post_reset[%0d]: got ctl=%b stall=%0d tmo=%b, want ctl=%b stall=%0d tmo=%b",
                         i, ctl_obs, stall_count, mem_timeout, e.ctl, e.stall, e.tmo);
            end
            @(posedge stg_clk); #1;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_stall = 16'd0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch(1'b0, "branch");
        test_branch(1'b1, "branch_vs_load_use");
        test_mem_freeze();
        test_freeze_in_flush();
        test_branch_on_release();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the `stg_ena`/`stg_x` pair of every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It detects load-use hazards, flushes wrong-path instructions after a taken branch, and freezes the whole pipeline while the data memory is busy. It sits beside the pipeline as the single control source for latch advance and bubble insertion. Enables and bubble requests are decoded in the same cycle from the current state and inputs; counters and state are registered.

## Interface
Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID is bubbled after a taken branch (≥1)
- MEM_TIMEOUT, 255, consecutive wait cycles before `mem_timeout` is raised (≥1)

Ports:
- stg_clk  in  1  pipeline clock; one clock for the whole block
- reset  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- ex_rd  in  5  destination of the instruction in EX
- ex_rd_memory  in  1  EX instruction is a load
- ex_save_to_reg  in  1  EX instruction writes rd
- branch_taken  in  1  EX resolved a taken branch or jump this cycle
- mem_req  in  1  MEM stage has an access outstanding
- mem_ready  in  1  data memory completes the access this cycle
- pc_ena  out  1  PC register load enable
- ifid_ena, idex_ena, exmem_ena, memwb_ena  out  1 each  latch advance
- ifid_x, idex_x, exmem_x  out  1 each  latch loads a bubble (all-zero NOP) instead of its inputs
- mem_timeout  out  1  sticky error flag
- stall_count  out  16  saturating count of cycles with `pc_ena`=0

## Operation
- Latch semantics: ena=0 → hold; ena=1, x=0 → load; ena=1, x=1 → load bubble. x is meaningless when ena=0 and is driven 0.
- States: RUN, FLUSH, MEM_WAIT. Reset → RUN, flush counter 0, wait counter 0, `mem_timeout`=0, `stall_count`=0.
- While `reset`=1: all ena and x outputs are 0.
- Priority, highest first: memory freeze > branch flush > load-use.
- Memory freeze: `mem_req` & !`mem_ready` → all ena=0, including `pc_ena`. RUN/FLUSH → MEM_WAIT, saving the flush residue. MEM_WAIT → previous state on `mem_ready`.
- Timeout: the wait counter increments every MEM_WAIT cycle. When it reaches MEM_TIMEOUT, `mem_timeout`=1 until reset. The freeze continues.
- Branch flush: `branch_taken` in RUN, not frozen → `pc_ena`=1, ifid_x=idex_x=1 (all ena=1), then FLUSH for FLUSH_CYCLES−1 more cycles. In those cycles ifid_x=1 and everything else advances normally. With FLUSH_CYCLES=1, stay in RUN.
- Load-use hazard: `ex_rd_memory` & `ex_save_to_reg` & `ex_rd`≠0 & ((`id_rs1_used` & `id_rs1`==`ex_rd`) | (`id_rs2_used` & `id_rs2`==`ex_rd`)). Response: `pc_ena`=0, `ifid_ena`=0, `idex_ena`=1 with idex_x=1, EX/MEM and MEM/WB advance. It resolves in one cycle by construction. Suppressed when `branch_taken`=1, because ID is wrong-path.
- `branch_taken` during a freeze is ignored. It is re-evaluated when the freeze releases, since EX is held.
- `stall_count` saturates at 0xFFFF.

## Timing
- Zero-cycle latency: outputs respond combinationally in the same cycle as the causing inputs. State and counters update on the `stg_clk` rising edge.
- Load-use costs exactly 1 bubble. A taken branch costs 1 + (FLUSH_CYCLES−1) bubbles in IF/ID and 1 in ID/EX.
- `mem_ready` in the same cycle as `mem_req` → no freeze and no state change.
- Reset asserted mid-flush or mid-wait → immediate return to reset values. First cycle after deassertion: RUN with all ena=1.

## Structure
- Shared pipeline package holds the state encoding (RUN/FLUSH/MEM_WAIT), the register-index width (5), and the bubble/NOP constant shared with the latches.
- Single module, no sub-modules. The load-use comparator is an inline function.

## Test plan
- ex load to x5, ID reads rs1=x5 → one cycle: pc_ena=0, ifid_ena=0, idex_x=1. Next cycle all ena=1, stall_count=1.
- ex load to x0 with ID reads x0 → no stall; ex non-load writing x5, ID reads x5 → no stall.
- branch_taken with FLUSH_CYCLES=2 → cycle 0: ifid_x=idex_x=1, pc_ena=1; cycle 1: ifid_x=1 only; cycle 2: RUN, all x=0.
- mem_req=1, mem_ready low for 3 cycles → all ena=0 for 3 cycles, stall_count=3, resume on mem_ready. With MEM_TIMEOUT=2, mem_timeout rises at the 2nd wait cycle and stays 1.
- branch_taken and load-use hazard in the same cycle → flush response only, no PC hold.
- reset pulse during MEM_WAIT → outputs 0 during reset, then RUN, counters 0, mem_timeout=0.
